// File: rtl/square_puls_decoder.sv
// ---------------------------------------------------------------------------
// square_puls_decoder
//
// Purpose:
//   Receive-side counterpart of the square pulse generator. Watches a strobed
//   stream of signed +/-1 samples. For each waveform period it measures the
//   period length and the high-phase length, both in samples. Each completed
//   measurement is reported with a single-cycle valid strobe.
//
// Ports:
//   clk_i                   system clock, everything on the rising edge
//   rst_i                   synchronous, active-high reset
//   data_i                  signed Q0.N_FRAC sample; HIGH when >= 0
//   data_in_valid_strobe_i  one-cycle qualifier for data_i
//   period_o                samples between two accepted rising edges
//   high_time_o             HIGH samples within that period
//   result_valid_strobe_o   one-cycle pulse marking a new measurement
//   locked_o                a full period has been measured since reset/overflow
//   overflow_strobe_o       one-cycle pulse: period exceeded counter range
//
// Optional feature:
//   Define SQUARE_PULS_DECODER_GLITCH_FILTER_EN to run the FSM on a filtered
//   level. The filtered level only follows a new raw level after two
//   consecutive strobed samples agree on it.
// ---------------------------------------------------------------------------
module square_puls_decoder #(
   parameter int N_FRAC = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N_FRAC:0]   data_i,
   input  logic              data_in_valid_strobe_i,
   output logic [CNT_W-1:0]  period_o,
   output logic [CNT_W-1:0]  high_time_o,
   output logic              result_valid_strobe_o,
   output logic              locked_o,
   output logic              overflow_strobe_o
);

   typedef enum logic [1:0] {
      SYNC    = 2'd0,
      ARMED   = 2'd1,
      HIGH_PH = 2'd2,
      LOW_PH  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] highCnt_q, highCnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] highTime_q, highTime_d;
   logic             resultValid_q, resultValid_d;
   logic             locked_q, locked_d;
   logic             overflow_q, overflow_d;

   logic             levelRaw;
   logic             level;

   // The sign bit alone decides the level. Zero counts as HIGH.
   assign levelRaw = ($signed(data_i) >= $signed((N_FRAC+1)'(0)));

`ifdef SQUARE_PULS_DECODER_GLITCH_FILTER_EN
   logic prevRaw_q;
   logic filtLevel_q;

   // The filtered level switches on the second of two agreeing raw samples.
   // A lone opposite sample is therefore treated as the current level.
   assign level = (levelRaw == prevRaw_q) ? levelRaw : filtLevel_q;

   // Filter history only advances on accepted samples. After reset it is LOW.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prevRaw_q   <= 1'b0;
         filtLevel_q <= 1'b0;
      end else if (data_in_valid_strobe_i) begin
         prevRaw_q   <= levelRaw;
         filtLevel_q <= level;
      end
   end
`else
   assign level = levelRaw;
`endif

   // State and result registers. Reset wins over a coincident strobe and
   // throws away any partial measurement.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= SYNC;
         cnt_q         <= '0;
         highCnt_q     <= '0;
         period_q      <= '0;
         highTime_q    <= '0;
         resultValid_q <= 1'b0;
         locked_q      <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         highCnt_q     <= highCnt_d;
         period_q      <= period_d;
         highTime_q    <= highTime_d;
         resultValid_q <= resultValid_d;
         locked_q      <= locked_d;
         overflow_q    <= overflow_d;
      end
   end

   // Next-state logic. Nothing moves without a strobe, and both strobes
   // drop back to 0 on every edge that does not raise them.
   // cnt counts samples since the last accepted rising edge.
   // highCnt counts the HIGH samples among them, so it can never exceed cnt.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      highCnt_d     = highCnt_q;
      period_d      = period_q;
      highTime_d    = highTime_q;
      resultValid_d = 1'b0;
      locked_d      = locked_q;
      overflow_d    = 1'b0;

      if (data_in_valid_strobe_i) begin
         case (state_q)
            SYNC: begin
               // Skip an initial high run: wait for LOW before arming.
               if (!level) begin
                  state_d = ARMED;
               end
            end
            ARMED: begin
               if (level) begin
                  cnt_d     = CNT_ONE;
                  highCnt_d = CNT_ONE;
                  state_d   = HIGH_PH;
               end
            end
            HIGH_PH: begin
               if (cnt_q == CNT_MAX) begin
                  overflow_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (level) begin
                     highCnt_d = highCnt_q + CNT_ONE;
                  end else begin
                     state_d = LOW_PH;
                  end
               end
            end
            LOW_PH: begin
               // A completing rising edge is always reported, even at CNT_MAX.
               // Only a further LOW sample can overflow here.
               if (level) begin
                  period_d      = cnt_q;
                  highTime_d    = highCnt_q;
                  resultValid_d = 1'b1;
                  locked_d      = 1'b1;
                  cnt_d         = CNT_ONE;
                  highCnt_d     = CNT_ONE;
                  state_d       = HIGH_PH;
               end else if (cnt_q == CNT_MAX) begin
                  overflow_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = SYNC;
            end
         endcase

         // On overflow, abandon the measurement but keep the last reported
         // values. A LOW sample may re-arm at once. A HIGH sample must first
         // wait for LOW.
         if (overflow_d) begin
            locked_d  = 1'b0;
            cnt_d     = '0;
            highCnt_d = '0;
            state_d   = level ? SYNC : ARMED;
         end
      end
   end

   assign period_o              = period_q;
   assign high_time_o           = highTime_q;
   assign result_valid_strobe_o = resultValid_q;
   assign locked_o              = locked_q;
   assign overflow_strobe_o     = overflow_q;

endmodule

// File: tb/tb_square_puls_decoder.sv
// ---------------------------------------------------------------------------
// tb_square_puls_decoder
//
// Drives two decoders from one strobed sample stream: the default build
// (CNT_W=16) and a narrow one (CNT_W=4) that exercises overflow. A reference
// model keeps the levels seen since the last rising edge in a queue. The
// period is the queue length and the high time is the count of HIGH entries.
// Honours SQUARE_PULS_DECODER_GLITCH_FILTER_EN.
// ---------------------------------------------------------------------------
module tb_square_puls_decoder;

   localparam logic [7:0] POS = 8'h7F;
   localparam logic [7:0] NEG = 8'h81;

   logic        clk    = 1'b0;
   logic        rst    = 1'b0;
   logic        strobe = 1'b0;
   logic [7:0]  data   = 8'h00;

   logic [15:0] periodA, highA;
   logic        validA, lockedA, ovfA;
   logic [3:0]  periodB, highB;
   logic        validB, lockedB, ovfB;

   logic [34:0] gotA;
   logic [10:0] gotB;

   int checks   = 0;
   int failures = 0;
   int resCount;

   logic [7:0] stimQ[$];

   // Reference model state
   bit runA[$];
   bit runB[$];
   int expPeriod[2];
   int expHigh[2];
   bit expValid[2];
   bit expLocked[2];
   bit expOvf[2];
   bit seenLow[2];
   bit prevRaw;
   bit lastEff;

   assign gotA = {periodA, highA, validA, lockedA, ovfA};
   assign gotB = {periodB, highB, validB, lockedB, ovfB};

   always #5 clk = ~clk;

   square_puls_decoder #(.N_FRAC(7), .CNT_W(16)) dutA (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .data_i                 (data),
      .data_in_valid_strobe_i (strobe),
      .period_o               (periodA),
      .high_time_o            (highA),
      .result_valid_strobe_o  (validA),
      .locked_o               (lockedA),
      .overflow_strobe_o      (ovfA)
   );

   square_puls_decoder #(.N_FRAC(7), .CNT_W(4)) dutB (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .data_i                 (data),
      .data_in_valid_strobe_i (strobe),
      .period_o               (periodB),
      .high_time_o            (highB),
      .result_valid_strobe_o  (validB),
      .locked_o               (lockedB),
      .overflow_strobe_o      (ovfB)
   );

   function automatic logic [34:0] expA();
      return {16'(expPeriod[0]), 16'(expHigh[0]), expValid[0], expLocked[0], expOvf[0]};
   endfunction

   function automatic logic [10:0] expB();
      return {4'(expPeriod[1]), 4'(expHigh[1]), expValid[1], expLocked[1], expOvf[1]};
   endfunction

   task automatic modelReset();
      for (int w = 0; w < 2; w++) begin
         expPeriod[w] = 0;
         expHigh[w]   = 0;
         expValid[w]  = 1'b0;
         expLocked[w] = 1'b0;
         expOvf[w]    = 1'b0;
         seenLow[w]   = 1'b0;
      end
      runA.delete();
      runB.delete();
      prevRaw = 1'b0;
      lastEff = 1'b0;
   endtask

   // One clock edge of the model. A rising edge that closes a period reports
   // the queue contents. A non-closing sample with a full queue overflows.
   task automatic modelStep(input bit strobeIn, input bit raw);
      bit lvl;
      bit run[$];
      int maxLen;
      for (int w = 0; w < 2; w++) begin
         expValid[w] = 1'b0;
         expOvf[w]   = 1'b0;
      end
      if (!strobeIn) return;
`ifdef SQUARE_PULS_DECODER_GLITCH_FILTER_EN
      lvl     = (raw == prevRaw) ? raw : lastEff;
      prevRaw = raw;
      lastEff = lvl;
`else
      lvl = raw;
`endif
      for (int w = 0; w < 2; w++) begin
         if (w == 0) begin
            run    = runA;
            maxLen = 65535;
         end else begin
            run    = runB;
            maxLen = 15;
         end
         if (run.size() == 0) begin
            if (!lvl) seenLow[w] = 1'b1;
            else if (seenLow[w]) run.push_back(1'b1);
         end else if (lvl && !run[run.size()-1]) begin
            expPeriod[w] = run.size();
            expHigh[w]   = 0;
            foreach (run[k]) expHigh[w] += int'(run[k]);
            expValid[w]  = 1'b1;
            expLocked[w] = 1'b1;
            run.delete();
            run.push_back(1'b1);
         end else if (run.size() == maxLen) begin
            run.delete();
            expOvf[w]    = 1'b1;
            expLocked[w] = 1'b0;
            seenLow[w]   = !lvl;
         end else begin
            run.push_back(lvl);
         end
         if (w == 0) runA = run;
         else        runB = run;
      end
   endtask

   // Present one strobed sample and sample the outputs 1 ns after its edge.
   task automatic applyStimulus(input logic [7:0] value);
      data   = value;
      strobe = 1'b1;
      @(posedge clk);
      #1;
      strobe = 1'b0;
      modelStep(1'b1, ~value[7]);
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
      modelStep(1'b0, 1'b0);
   endtask

   task automatic resetDut(input bit withStrobe);
      rst    = 1'b1;
      strobe = withStrobe;
      data   = NEG;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      strobe = 1'b0;
      modelReset();
   endtask

   task automatic addRun(input logic [7:0] v, input int n);
      repeat (n) stimQ.push_back(v);
   endtask

   task automatic test_reset();
      resetDut(1'b1);
      checks++;
      if (gotA !== 35'd0) begin
         failures++;
         $display("[TB] FAIL reset_w16 got=%h exp=0", gotA);
      end
      checks++;
      if (gotB !== 11'd0) begin
         failures++;
         $display("[TB] FAIL reset_w4 got=%h exp=0", gotB);
      end
   endtask

   task automatic test_basic();
      resetDut(1'b0);
      stimQ.delete();
      addRun(NEG, 3); addRun(POS, 5); addRun(NEG, 3); addRun(POS, 1);
`ifdef SQUARE_PULS_DECODER_GLITCH_FILTER_EN
      addRun(POS, 1);
`endif
      for (int i = 0; i < stimQ.size(); i++) begin
         applyStimulus(stimQ[i]);
         checks++;
         if (gotA !== expA()) begin
            failures++;
            $display("[TB] FAIL basic_w16 i=%0d got=%h exp=%h", i, gotA, expA());
         end
         checks++;
         if (gotB !== expB()) begin
            failures++;
            $display("[TB] FAIL basic_w4 i=%0d got=%h exp=%h", i, gotB, expB());
         end
      end
      checks++;
      if ({periodA, highA, validA, lockedA} !== {16'd8, 16'd5, 1'b1, 1'b1}) begin
         failures++;
         $display("[TB] FAIL basic_result got=%0d/%0d v%0b l%0b exp=8/5 v1 l1", periodA, highA, validA, lockedA);
      end
      idleCycle();
      checks++;
      if (gotA !== expA()) begin
         failures++;
         $display("[TB] FAIL basic_idle got=%h exp=%h", gotA, expA());
      end
   endtask

   task automatic test_start_high();
      resetDut(1'b0);
      stimQ.delete();
      addRun(POS, 4); addRun(NEG, 4); addRun(POS, 4); addRun(NEG, 4); addRun(POS, 1);
      resCount = 0;
      for (int i = 0; i < stimQ.size(); i++) begin
         applyStimulus(stimQ[i]);
         if (validA) resCount++;
         checks++;
         if (gotA !== expA()) begin
            failures++;
            $display("[TB] FAIL start_high_w16 i=%0d got=%h exp=%h", i, gotA, expA());
         end
         checks++;
         if (gotB !== expB()) begin
            failures++;
            $display("[TB] FAIL start_high_w4 i=%0d got=%h exp=%h", i, gotB, expB());
         end
      end
`ifndef SQUARE_PULS_DECODER_GLITCH_FILTER_EN
      checks++;
      if (resCount !== 1 || periodA !== 16'd8 || highA !== 16'd4) begin
         failures++;
         $display("[TB] FAIL start_high_result got n=%0d %0d/%0d exp n=1 8/4", resCount, periodA, highA);
      end
`endif
   endtask

   task automatic test_gaps_wave(input int maxGap);
      int gap;
      resetDut(1'b0);
      stimQ.delete();
      for (int p = 0; p < 5; p++) begin
         addRun(NEG, 192);
         addRun(POS, 64);
      end
      resCount = 0;
      for (int i = 0; i < stimQ.size(); i++) begin
         applyStimulus(stimQ[i]);
         checks++;
         if (gotA !== expA() || gotB !== expB()) begin
            failures++;
            $display("[TB] FAIL wave_gap%0d i=%0d got=%h/%h exp=%h/%h", maxGap, i, gotA, gotB, expA(), expB());
         end
         if (validA) begin
            resCount++;
            checks++;
            if (periodA !== 16'd256 || highA !== 16'd64) begin
               failures++;
               $display("[TB] FAIL wave_value got=%0d/%0d exp=256/64", periodA, highA);
            end
         end
         gap = $urandom_range(0, maxGap);
         repeat (gap) begin
            idleCycle();
            checks++;
            if (gotA !== expA() || gotB !== expB()) begin
               failures++;
               $display("[TB] FAIL wave_idle i=%0d got=%h/%h exp=%h/%h", i, gotA, gotB, expA(), expB());
            end
         end
      end
      checks++;
      if (resCount !== 4) begin
         failures++;
         $display("[TB] FAIL wave_count gap%0d got=%0d exp=4", maxGap, resCount);
      end
   endtask

   task automatic test_overflow();
      resetDut(1'b0);
      stimQ.delete();
      addRun(NEG, 3); addRun(POS, 5); addRun(NEG, 3); addRun(POS, 1);
      addRun(POS, 16);
      addRun(NEG, 3); addRun(POS, 5); addRun(NEG, 3); addRun(POS, 1);
      for (int j = 0; j < stimQ.size(); j++) begin
         applyStimulus(stimQ[j]);
         checks++;
         if (gotA !== expA()) begin
            failures++;
            $display("[TB] FAIL overflow_w16 j=%0d got=%h exp=%h", j, gotA, expA());
         end
         checks++;
         if (gotB !== expB()) begin
            failures++;
            $display("[TB] FAIL overflow_w4 j=%0d got=%h exp=%h", j, gotB, expB());
         end
`ifndef SQUARE_PULS_DECODER_GLITCH_FILTER_EN
         if (j == 26) begin
            checks++;
            if ({ovfB, lockedB, periodB, highB, ovfA, lockedA} !== {1'b1, 1'b0, 4'd8, 4'd5, 1'b0, 1'b1}) begin
               failures++;
               $display("[TB] FAIL overflow_hit got o%0b l%0b %0d/%0d A o%0b l%0b exp o1 l0 8/5 A o0 l1",
                        ovfB, lockedB, periodB, highB, ovfA, lockedA);
            end
         end
`endif
      end
`ifndef SQUARE_PULS_DECODER_GLITCH_FILTER_EN
      checks++;
      if ({validB, lockedB, periodB, highB} !== {1'b1, 1'b1, 4'd8, 4'd5}) begin
         failures++;
         $display("[TB] FAIL overflow_relock got v%0b l%0b %0d/%0d exp v1 l1 8/5", validB, lockedB, periodB, highB);
      end
`endif
   endtask

   task automatic test_reset_mid();
      resetDut(1'b0);
      stimQ.delete();
      addRun(NEG, 3); addRun(POS, 5); addRun(NEG, 3); addRun(POS, 3); addRun(NEG, 2);
      for (int i = 0; i < stimQ.size(); i++) begin
         applyStimulus(stimQ[i]);
         checks++;
         if (gotA !== expA() || gotB !== expB()) begin
            failures++;
            $display("[TB] FAIL reset_mid_pre i=%0d got=%h/%h exp=%h/%h", i, gotA, gotB, expA(), expB());
         end
      end
      resetDut(1'b1);
      checks++;
      if (gotA !== 35'd0 || gotB !== 11'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_clear got=%h/%h exp=0/0", gotA, gotB);
      end
      applyStimulus(NEG);
      applyStimulus(POS);
      checks++;
      if (validA !== 1'b0 || validB !== 1'b0 || gotA !== expA()) begin
         failures++;
         $display("[TB] FAIL reset_mid_noreport got=%h/%h exp=%h/%h", gotA, gotB, expA(), expB());
      end
   endtask

   task automatic test_glitch();
`ifdef SQUARE_PULS_DECODER_GLITCH_FILTER_EN
      resetDut(1'b0);
      stimQ.delete();
      addRun(NEG, 10); addRun(POS, 1); addRun(NEG, 9); addRun(POS, 6); addRun(NEG, 4); addRun(POS, 2);
      resCount = 0;
      for (int i = 0; i < stimQ.size(); i++) begin
         applyStimulus(stimQ[i]);
         if (validA) resCount++;
         checks++;
         if (gotA !== expA()) begin
            failures++;
            $display("[TB] FAIL glitch_model i=%0d got=%h exp=%h", i, gotA, expA());
         end
      end
      checks++;
      if (resCount !== 1 || {periodA, highA, validA} !== {16'd10, 16'd6, 1'b1}) begin
         failures++;
         $display("[TB] FAIL glitch_result got n=%0d %0d/%0d v%0b exp n=1 10/6 v1", resCount, periodA, highA, validA);
      end
`endif
   endtask

   task automatic test_random();
      int  n;
      int  len;
      bit  lvl;
      logic [7:0] v;
      resetDut(1'b0);
      n = 0;
      while (n < 600) begin
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++) begin
            v = lvl ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
            applyStimulus(v);
            n++;
            checks++;
            if (gotA !== expA() || gotB !== expB()) begin
               failures++;
               $display("[TB] FAIL random n=%0d data=%h got=%h/%h exp=%h/%h", n, v, gotA, gotB, expA(), expB());
            end
            if ($urandom_range(0, 3) == 0) begin
               idleCycle();
               checks++;
               if (gotA !== expA() || gotB !== expB()) begin
                  failures++;
                  $display("[TB] FAIL random_idle n=%0d got=%h/%h exp=%h/%h", n, gotA, gotB, expA(), expB());
               end
            end
         end
      end
   endtask

   // Run every scenario in turn, then print the single summary line.
   initial begin
      test_reset();
      test_basic();
      test_start_high();
      test_gaps_wave(0);
      test_gaps_wave(3);
      test_overflow();
      test_reset_mid();
      test_glitch();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
